svc_rv_dmem_stall_adapter: RTL and testbench

Bridges the svc_rv core's data-memory port (BRAM timing, MEM_TYPE=1, with dmem_stall) to a variable-latency backing memory with a valid/ready request channel and a valid-only response channel. It samples one core access at a time, raises dmem_stall until the backing memory completes it, and holds read data stable for the core's writeback stage. It sits directly downstream of the core's dmem port, in place of a fixed-latency BRAM.

---
 rtl/svc_rv_dmem_pkg.sv | 16 +
 rtl/svc_rv_dmem_stall_adapter.sv | 142 ++++++++++++++
 tb/tb_svc_rv_dmem_stall_adapter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/svc_rv_dmem_pkg.sv
// Shared definitions for the svc_rv data-memory path: adapter state
// encoding and the byte-strobe width helper used by core and adapter.
package svc_rv_dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } state_e;

  // One strobe bit per byte of the data word.
  function automatic int wstrb_width(input int xlen);
    return xlen / 8;
  endfunction

endpackage

// File: rtl/svc_rv_dmem_stall_adapter.sv
// Bridges the core's BRAM-timed dmem port to a variable-latency backing
// memory. One access in flight at a time; dmem_stall freezes the core until
// the backing memory accepts a write or returns read data.
module svc_rv_dmem_stall_adapter
  import svc_rv_dmem_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int AW       = 32,
  parameter int MAX_WAIT = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          dmem_ren,
  input  logic [AW-1:0]                 dmem_raddr,
  output logic [XLEN-1:0]               dmem_rdata,
  input  logic                          dmem_we,
  input  logic [AW-1:0]                 dmem_waddr,
  input  logic [XLEN-1:0]               dmem_wdata,
  input  logic [wstrb_width(XLEN)-1:0]  dmem_wstrb,
  output logic                          dmem_stall,
  output logic                          m_req_valid,
  input  logic                          m_req_ready,
  output logic                          m_req_write,
  output logic [AW-1:0]                 m_req_addr,
  output logic [XLEN-1:0]               m_req_wdata,
  output logic [wstrb_width(XLEN)-1:0]  m_req_wstrb,
  input  logic                          m_rsp_valid,
  input  logic [XLEN-1:0]               m_rsp_rdata,
  output logic                          err_proto,
  output logic                          err_timeout,
  output logic [31:0]                   stall_cycles
);

  localparam int SW = wstrb_width(XLEN);
  localparam int WW = $clog2(MAX_WAIT + 1);

  state_e            state_q,        state_d;
  logic              req_write_q,    req_write_d;
  logic [AW-1:0]     req_addr_q,     req_addr_d;
  logic [XLEN-1:0]   req_wdata_q,    req_wdata_d;
  logic [SW-1:0]     req_wstrb_q,    req_wstrb_d;
  logic [XLEN-1:0]   rdata_q,        rdata_d;
  logic              err_proto_q,    err_proto_d;
  logic              err_timeout_q,  err_timeout_d;
  logic [31:0]       stall_cycles_q, stall_cycles_d;
  logic [WW-1:0]     wait_q,         wait_d;

  logic stalled;
  assign stalled = (state_q != ST_IDLE);

  // Next-state, request capture, error flags and counters.
  always_comb begin
    // NOTE: every _d defaults to its _q first so no path leaves a variable
    // unassigned; that is what keeps this block free of inferred latches.
    state_d        = state_q;
    req_write_d    = req_write_q;
    req_addr_d     = req_addr_q;
    req_wdata_d    = req_wdata_q;
    req_wstrb_d    = req_wstrb_q;
    rdata_d        = rdata_q;
    err_proto_d    = err_proto_q;
    err_timeout_d  = err_timeout_q;
    stall_cycles_d = stall_cycles_q;
    wait_d         = wait_q;

    unique case (state_q)
      ST_IDLE: begin
        if (dmem_we || dmem_ren) begin
          // Write wins when both are asserted; that combination is illegal.
          state_d     = ST_REQ;
          req_write_d = dmem_we;
          req_addr_d  = dmem_we ? dmem_waddr : dmem_raddr;
          req_wdata_d = dmem_wdata;
          req_wstrb_d = dmem_we ? dmem_wstrb : '0;
          wait_d      = '0;
          if (dmem_we && dmem_ren) err_proto_d = 1'b1;
        end
      end
      ST_REQ: begin
        // Writes are posted: no response is expected after acceptance.
        if (m_req_ready) state_d = req_write_q ? ST_IDLE : ST_RSP;
      end
      ST_RSP: begin
        if (m_rsp_valid) begin
          rdata_d = m_rsp_rdata;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A response is only legal while a read is waiting for it.
    if (m_rsp_valid && (state_q != ST_RSP)) err_proto_d = 1'b1;

    if (stalled) begin
      if (wait_q != WW'(MAX_WAIT))     wait_d = wait_q + 1'b1;
      if (wait_q == WW'(MAX_WAIT - 1)) err_timeout_d = 1'b1;
      if (stall_cycles_q != '1)        stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      req_write_q    <= 1'b0;
      req_addr_q     <= '0;
      req_wdata_q    <= '0;
      req_wstrb_q    <= '0;
      rdata_q        <= '0;
      err_proto_q    <= 1'b0;
      err_timeout_q  <= 1'b0;
      stall_cycles_q <= '0;
      wait_q         <= '0;
    end else begin
      state_q        <= state_d;
      req_write_q    <= req_write_d;
      req_addr_q     <= req_addr_d;
      req_wdata_q    <= req_wdata_d;
      req_wstrb_q    <= req_wstrb_d;
      rdata_q        <= rdata_d;
      err_proto_q    <= err_proto_d;
      err_timeout_q  <= err_timeout_d;
      stall_cycles_q <= stall_cycles_d;
      wait_q         <= wait_d;
    end
  end

  assign dmem_stall   = stalled;
  assign m_req_valid  = (state_q == ST_REQ);
  assign m_req_write  = req_write_q;
  assign m_req_addr   = req_addr_q;
  assign m_req_wdata  = req_wdata_q;
  assign m_req_wstrb  = req_wstrb_q;
  assign dmem_rdata   = rdata_q;
  assign err_proto    = err_proto_q;
  assign err_timeout  = err_timeout_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_svc_rv_dmem_stall_adapter.sv
// Self-checking bench for svc_rv_dmem_stall_adapter: vector table, corner
// sequences and randomized accesses against a transaction-level model.
module tb_svc_rv_dmem_stall_adapter;

  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dmem_ren, dmem_we;
  logic [31:0] dmem_raddr, dmem_waddr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_stall;
  logic        m_req_valid, m_req_ready, m_req_write;
  logic [31:0] m_req_addr, m_req_wdata;
  logic [3:0]  m_req_wstrb;
  logic        m_rsp_valid;
  logic [31:0] m_rsp_rdata;
  logic        err_proto, err_timeout;
  logic [31:0] stall_cycles;

  always #5 clk = ~clk;

  svc_rv_dmem_stall_adapter #(.XLEN(32), .AW(32), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .dmem_ren(dmem_ren), .dmem_raddr(dmem_raddr), .dmem_rdata(dmem_rdata),
    .dmem_we(dmem_we), .dmem_waddr(dmem_waddr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_stall(dmem_stall),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
    .m_req_write(m_req_write), .m_req_addr(m_req_addr),
    .m_req_wdata(m_req_wdata), .m_req_wstrb(m_req_wstrb),
    .m_rsp_valid(m_rsp_valid), .m_rsp_rdata(m_rsp_rdata),
    .err_proto(err_proto), .err_timeout(err_timeout),
    .stall_cycles(stall_cycles)
  );

  int total = 0;
  int bad   = 0;

  // Transaction-level model state.
  logic [31:0] exp_rdata;
  longint      exp_stall_total;
  logic        exp_proto;
  logic        exp_timeout;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rsp;
    int          req_lat;
    int          rsp_lat;
    int          exp_stall;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_rdata       = '0;
    exp_stall_total = 0;
    exp_proto       = 1'b0;
    exp_timeout     = 1'b0;
  endtask

  // Issue one core access from an IDLE cycle and play the backing memory
  // with req_lat cycles of withheld ready and rsp_lat cycles of withheld
  // response. Returns the number of cycles dmem_stall was observed high.
  task automatic run_access(input logic wr, input logic rd,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, input logic [31:0] rsp,
                            input int req_lat, input int rsp_lat,
                            output int stalls);
    int s;
    int exp_len;
    dmem_we    = wr;
    dmem_ren   = rd;
    dmem_waddr = addr;
    dmem_raddr = addr;
    dmem_wdata = wdata;
    dmem_wstrb = strb;
    check("idle_before_req", {63'd0, dmem_stall}, 64'd0);
    @(posedge clk); #1;
    dmem_we    = 1'b0;
    dmem_ren   = 1'b0;
    dmem_raddr = $urandom;
    dmem_waddr = $urandom;
    dmem_wdata = $urandom;
    stalls = 0;
    s = 0;
    for (int k = 0; k <= req_lat; k++) begin
      m_req_ready = (k == req_lat);
      @(negedge clk);
      s++;
      stalls += int'(dmem_stall);
      check("req_valid", {63'd0, m_req_valid}, 64'd1);
      check("req_write", {63'd0, m_req_write}, {63'd0, wr});
      check("req_addr",  {32'd0, m_req_addr}, {32'd0, addr});
      check("req_wstrb", {60'd0, m_req_wstrb}, wr ? {60'd0, strb} : 64'd0);
      if (wr) check("req_wdata", {32'd0, m_req_wdata}, {32'd0, wdata});
      check("timeout_req", {63'd0, err_timeout}, {63'd0, exp_timeout || (s > MAX_WAIT)});
      @(posedge clk); #1;
    end
    m_req_ready = 1'b0;
    if (!wr) begin
      for (int j = 0; j <= rsp_lat; j++) begin
        m_rsp_valid = (j == rsp_lat);
        m_rsp_rdata = (j == rsp_lat) ? rsp : $urandom;
        @(negedge clk);
        s++;
        stalls += int'(dmem_stall);
        check("rsp_no_req_valid", {63'd0, m_req_valid}, 64'd0);
        check("rdata_held_rsp", {32'd0, dmem_rdata}, {32'd0, exp_rdata});
        check("timeout_rsp", {63'd0, err_timeout}, {63'd0, exp_timeout || (s > MAX_WAIT)});
        @(posedge clk); #1;
      end
    end
    m_rsp_valid = 1'b0;
    // Model: stall length from the latency rules, then sticky flags.
    exp_len = req_lat + 1 + (wr ? 0 : rsp_lat + 1);
    if (!wr) exp_rdata = rsp;
    exp_stall_total += exp_len;
    if (wr && rd) exp_proto = 1'b1;
    if (exp_len >= MAX_WAIT) exp_timeout = 1'b1;
    @(negedge clk);
    check("done_stall", {63'd0, dmem_stall}, 64'd0);
    check("done_rdata", {32'd0, dmem_rdata}, {32'd0, exp_rdata});
    check("done_stall_cycles", {32'd0, stall_cycles}, 64'(exp_stall_total));
    check("done_err_proto", {63'd0, err_proto}, {63'd0, exp_proto});
    check("done_err_timeout", {63'd0, err_timeout}, {63'd0, exp_timeout});
    check("stall_len", 64'(stalls), 64'(exp_len));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_stall"},     {63'd0, dmem_stall}, 64'd0);
    check({tag, "_req_valid"}, {63'd0, m_req_valid}, 64'd0);
    check({tag, "_req_write"}, {63'd0, m_req_write}, 64'd0);
    check({tag, "_req_addr"},  {32'd0, m_req_addr}, 64'd0);
    check({tag, "_req_wdata"}, {32'd0, m_req_wdata}, 64'd0);
    check({tag, "_req_wstrb"}, {60'd0, m_req_wstrb}, 64'd0);
    check({tag, "_rdata"},     {32'd0, dmem_rdata}, 64'd0);
    check({tag, "_err_proto"}, {63'd0, err_proto}, 64'd0);
    check({tag, "_err_to"},    {63'd0, err_timeout}, 64'd0);
    check({tag, "_stall_cnt"}, {32'd0, stall_cycles}, 64'd0);
  endtask

  initial begin
    int st;
    logic wr;

    vecs[0] = '{1'b0, 32'h40, 32'h0,        4'h0, 32'hDEADBEEF, 0, 0, 2, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 32'h10, 32'h12345678, 4'h3, 32'h0,        3, 0, 4, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 32'h44, 32'h0,        4'h0, 32'hCAFEF00D, 1, 2, 5, 32'hCAFEF00D};
    vecs[3] = '{1'b1, 32'h48, 32'hA5A5A5A5, 4'hF, 32'h0,        0, 0, 1, 32'hCAFEF00D};

    rst_n = 1'b0;
    dmem_ren = 1'b0; dmem_we = 1'b0;
    dmem_raddr = '0; dmem_waddr = '0; dmem_wdata = '0; dmem_wstrb = '0;
    m_req_ready = 1'b0; m_rsp_valid = 1'b0; m_rsp_rdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;

    // Vector table; each access starts in the first IDLE cycle after the
    // previous one, so the read->write pair exercises back-to-back sampling.
    for (int i = 0; i < 4; i++) begin
      run_access(vecs[i].wr, !vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                 vecs[i].strb, vecs[i].rsp, vecs[i].req_lat, vecs[i].rsp_lat, st);
      check($sformatf("vec%0d_stall", i), 64'(st), 64'(vecs[i].exp_stall));
      check($sformatf("vec%0d_rdata", i), {32'd0, dmem_rdata}, {32'd0, vecs[i].exp_rd});
    end

    // Spurious response while idle.
    m_rsp_valid = 1'b1;
    m_rsp_rdata = 32'hBAD0BAD0;
    @(posedge clk); #1;
    m_rsp_valid = 1'b0;
    exp_proto = 1'b1;
    @(negedge clk);
    check("spurious_proto", {63'd0, err_proto}, 64'd1);
    check("spurious_rdata", {32'd0, dmem_rdata}, {32'd0, exp_rdata});
    check("spurious_stall", {63'd0, dmem_stall}, 64'd0);

    // Simultaneous read and write: the write is performed.
    run_access(1'b1, 1'b1, 32'h20, 32'h0F0F0F0F, 4'hC, 32'h0, 0, 0, st);
    check("both_stall", 64'(st), 64'd1);

    // Randomized accesses against the model.
    for (int n = 0; n < 40; n++) begin
      wr = 1'($urandom_range(0, 1));
      run_access(wr, !wr, {$urandom_range(0, 255), 2'b00} , $urandom, 4'($urandom),
                 $urandom, $urandom_range(0, 3), $urandom_range(0, 3), st);
    end

    // Reset while waiting in RSP abandons the read.
    dmem_ren = 1'b1; dmem_raddr = 32'h60;
    @(posedge clk); #1;
    dmem_ren = 1'b0;
    m_req_ready = 1'b1;
    @(posedge clk); #1;
    m_req_ready = 1'b0;
    @(negedge clk);
    check("pre_reset_in_rsp", {63'd0, dmem_stall & ~m_req_valid}, 64'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    check_reset_state("midrst");

    // Timeout: response withheld 6 cycles, 8 stall cycles in total.
    run_access(1'b0, 1'b1, 32'h80, 32'h0, 4'h0, 32'h5A5AA5A5, 0, 6, st);
    check("timeout_set", {63'd0, err_timeout}, 64'd1);
    check("timeout_rdata", {32'd0, dmem_rdata}, 64'h5A5AA5A5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard bound on run time.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
